ysyx_23060072_mem_arbiter: RTL and testbench

YSYX_23060072_MEM_ARBITER -- requirements
Module: ysyx_23060072_mem_arbiter

---
 rtl/ysyx_23060072_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_ysyx_23060072_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_mem_arbiter.sv
// Shares one slave port between instruction fetch and LSU with one transaction in flight.
// LSU has priority, fetch is forced through after STARVE_LIMIT losses, and slave silence is cut off by a timeout.
module ysyx_23060072_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] rdata_o,
    output logic        slv_req_o,
    output logic        slv_we_o,
    output logic [31:0] slv_addr_o,
    output logic [31:0] slv_wdata_o,
    input  logic [31:0] slv_rdata_i,
    input  logic        slv_rvalid_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_LSU = 2'd2
    } state_e;

    localparam int              SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]      TMO_MAX    = 8'(TIMEOUT);

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [7:0]    tmo_q, tmo_d;
    logic          if_gnt_q, if_gnt_d;
    logic          lsu_gnt_q, lsu_gnt_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          lsu_rvalid_q, lsu_rvalid_d;
    logic          bus_err_q, bus_err_d;
    logic          slv_req_q, slv_req_d;
    logic          slv_we_q, slv_we_d;
    logic [31:0]   slv_addr_q, slv_addr_d;
    logic [31:0]   slv_wdata_q, slv_wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          lsu_wins;

    // Fetch only overrides the LSU once it has lost STARVE_LIMIT times in a row.
    assign lsu_wins = lsu_req_i && !(if_req_i && (starve_q == STARVE_MAX));

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        tmo_d        = tmo_q;
        if_gnt_d     = 1'b0;
        lsu_gnt_d    = 1'b0;
        if_rvalid_d  = 1'b0;
        lsu_rvalid_d = 1'b0;
        bus_err_d    = 1'b0;
        slv_req_d    = 1'b0;
        slv_we_d     = slv_we_q;
        slv_addr_d   = slv_addr_q;
        slv_wdata_d  = slv_wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (lsu_wins) begin
                    state_d     = BUSY_LSU;
                    lsu_gnt_d   = 1'b1;
                    slv_req_d   = 1'b1;
                    slv_we_d    = lsu_we_i;
                    slv_addr_d  = lsu_addr_i;
                    slv_wdata_d = lsu_wdata_i;
                    tmo_d       = 8'd0;
                    if (if_req_i && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else if (if_req_i) begin
                    state_d     = BUSY_IF;
                    if_gnt_d    = 1'b1;
                    slv_req_d   = 1'b1;
                    slv_we_d    = 1'b0;
                    slv_addr_d  = if_addr_i;
                    slv_wdata_d = 32'd0;
                    tmo_d       = 8'd0;
                    starve_d    = '0;
                end
            end
            BUSY_IF, BUSY_LSU: begin
                // A response arriving on the timeout cycle still counts as a good response.
                if (slv_rvalid_i) begin
                    state_d      = IDLE;
                    rdata_d      = slv_rdata_i;
                    if_rvalid_d  = (state_q == BUSY_IF);
                    lsu_rvalid_d = (state_q == BUSY_LSU);
                end else if (tmo_q == TMO_MAX) begin
                    state_d      = IDLE;
                    rdata_d      = 32'd0;
                    bus_err_d    = 1'b1;
                    if_rvalid_d  = (state_q == BUSY_IF);
                    lsu_rvalid_d = (state_q == BUSY_LSU);
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            tmo_q        <= 8'd0;
            if_gnt_q     <= 1'b0;
            lsu_gnt_q    <= 1'b0;
            if_rvalid_q  <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            slv_req_q    <= 1'b0;
            slv_we_q     <= 1'b0;
            slv_addr_q   <= 32'd0;
            slv_wdata_q  <= 32'd0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            tmo_q        <= tmo_d;
            if_gnt_q     <= if_gnt_d;
            lsu_gnt_q    <= lsu_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            bus_err_q    <= bus_err_d;
            slv_req_q    <= slv_req_d;
            slv_we_q     <= slv_we_d;
            slv_addr_q   <= slv_addr_d;
            slv_wdata_q  <= slv_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign if_gnt_o     = if_gnt_q;
    assign lsu_gnt_o    = lsu_gnt_q;
    assign if_rvalid_o  = if_rvalid_q;
    assign lsu_rvalid_o = lsu_rvalid_q;
    assign bus_err_o    = bus_err_q;
    assign slv_req_o    = slv_req_q;
    assign slv_we_o     = slv_we_q;
    assign slv_addr_o   = slv_addr_q;
    assign slv_wdata_o  = slv_wdata_q;
    assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_ysyx_23060072_mem_arbiter.sv
// Bench for the fetch/LSU memory arbiter: vector table, corner sequences, then random
// traffic checked against a transaction-level model of arbitration and starvation.
module tb_ysyx_23060072_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_gnt_o;
    logic        lsu_rvalid_o;
    logic [31:0] rdata_o;
    logic        slv_req_o;
    logic        slv_we_o;
    logic [31:0] slv_addr_o;
    logic [31:0] slv_wdata_o;
    logic [31:0] slv_rdata_i;
    logic        slv_rvalid_i;
    logic        bus_err_o;

    int          n_checks;
    int          n_errors;
    logic [31:0] last_rdata;

    ysyx_23060072_mem_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .lsu_req_i   (lsu_req_i),
        .lsu_we_i    (lsu_we_i),
        .lsu_addr_i  (lsu_addr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .lsu_gnt_o   (lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o),
        .rdata_o     (rdata_o),
        .slv_req_o   (slv_req_o),
        .slv_we_o    (slv_we_o),
        .slv_addr_o  (slv_addr_o),
        .slv_wdata_o (slv_wdata_o),
        .slv_rdata_i (slv_rdata_i),
        .slv_rvalid_i(slv_rvalid_i),
        .bus_err_o   (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        ireq;
        logic        lreq;
        logic        lwe;
        logic [31:0] iaddr;
        logic [31:0] laddr;
        logic [31:0] lwdata;
        logic [31:0] sdata;
        int          dly;
        logic        e_if;
        logic        e_lsu;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_if_gnt"}, if_gnt_o, 1'b0);
        check1({tag, "_lsu_gnt"}, lsu_gnt_o, 1'b0);
        check1({tag, "_if_rvalid"}, if_rvalid_o, 1'b0);
        check1({tag, "_lsu_rvalid"}, lsu_rvalid_o, 1'b0);
        check1({tag, "_bus_err"}, bus_err_o, 1'b0);
        check1({tag, "_slv_req"}, slv_req_o, 1'b0);
        check1({tag, "_slv_we"}, slv_we_o, 1'b0);
        check32({tag, "_slv_addr"}, slv_addr_o, 32'd0);
        check32({tag, "_slv_wdata"}, slv_wdata_o, 32'd0);
        check32({tag, "_rdata"}, rdata_o, 32'd0);
    endtask

    // Call in an IDLE cycle with requests already driven. dly = cycles from slv_req to
    // slave response; dly > TIMEOUT means the slave never answers.
    task automatic do_txn(input logic e_if, input logic e_lsu, input logic e_we,
                          input logic [31:0] e_addr, input logic [31:0] e_wdata,
                          input int dly, input logic [31:0] sdata);
        tick();
        check1("if_gnt", if_gnt_o, e_if);
        check1("lsu_gnt", lsu_gnt_o, e_lsu);
        check1("slv_req", slv_req_o, e_if | e_lsu);
        if (!(e_if || e_lsu)) begin
            check32("rdata_hold_idle", rdata_o, last_rdata);
            return;
        end
        check1("slv_we", slv_we_o, e_we);
        check32("slv_addr", slv_addr_o, e_addr);
        check32("slv_wdata", slv_wdata_o, e_wdata);
        if (e_if) if_req_i = 1'b0;
        else lsu_req_i = 1'b0;
        if (dly > TIMEOUT) begin
            repeat (TIMEOUT) tick();
            check1("early_if_rvalid", if_rvalid_o, 1'b0);
            check1("early_lsu_rvalid", lsu_rvalid_o, 1'b0);
            check1("early_bus_err", bus_err_o, 1'b0);
            slv_rdata_i = $urandom();
            tick();
            check1("tmo_if_rvalid", if_rvalid_o, e_if);
            check1("tmo_lsu_rvalid", lsu_rvalid_o, e_lsu);
            check1("tmo_bus_err", bus_err_o, 1'b1);
            check32("tmo_rdata", rdata_o, 32'd0);
            check1("tmo_gnt_pulse", if_gnt_o | lsu_gnt_o | slv_req_o, 1'b0);
            last_rdata = 32'd0;
        end else begin
            repeat (dly) begin
                tick();
                check1("wait_rvalid", if_rvalid_o | lsu_rvalid_o, 1'b0);
                check32("wait_rdata_hold", rdata_o, last_rdata);
            end
            slv_rvalid_i = 1'b1;
            slv_rdata_i  = sdata;
            tick();
            slv_rvalid_i = 1'b0;
            slv_rdata_i  = $urandom();
            check1("rsp_if_rvalid", if_rvalid_o, e_if);
            check1("rsp_lsu_rvalid", lsu_rvalid_o, e_lsu);
            check1("rsp_bus_err", bus_err_o, 1'b0);
            check32("rsp_rdata", rdata_o, sdata);
            check32("rsp_addr_hold", slv_addr_o, e_addr);
            check1("rsp_gnt_pulse", if_gnt_o | lsu_gnt_o | slv_req_o, 1'b0);
            last_rdata = sdata;
        end
    endtask

    vec_t        vecs[10];
    int          starve_m;
    logic        w_if;
    logic        w_lsu;
    int          dly;
    logic [31:0] sdata;

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        last_rdata   = 32'd0;
        rst          = 1'b1;
        if_req_i     = 1'b0;
        if_addr_i    = 32'd0;
        lsu_req_i    = 1'b0;
        lsu_we_i     = 1'b0;
        lsu_addr_i   = 32'd0;
        lsu_wdata_i  = 32'd0;
        slv_rdata_i  = 32'd0;
        slv_rvalid_i = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 32'h0000_0013, 1,
                    1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0001, 2,
                    1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'h0, 32'h0, 32'h0000_0093, 0,
                    1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0,
                    1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_2000, 32'h0000_0055, 32'h1234_5678, 3,
                    1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0055};
        for (int k = 0; k < 4; k++) begin
            vecs[5 + k] = '{1'b1, 1'b1, 1'b0, 32'h8000_0100, 32'h0000_3000 + 32'(4 * k), 32'h0,
                            32'h0000_00A0 + 32'(k), 1,
                            1'b0, 1'b1, 1'b0, 32'h0000_3000 + 32'(4 * k), 32'h0};
        end
        vecs[9] = '{1'b1, 1'b1, 1'b1, 32'h8000_0100, 32'h0000_4000, 32'hCAFE_F00D, 32'h0000_00BB, 1,
                    1'b1, 1'b0, 1'b0, 32'h8000_0100, 32'h0};

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Vector table: each row is one arbitration from IDLE; losers withdraw afterwards.
        for (int i = 0; i < 10; i++) begin
            if_req_i    = vecs[i].ireq;
            if_addr_i   = vecs[i].iaddr;
            lsu_req_i   = vecs[i].lreq;
            lsu_we_i    = vecs[i].lwe;
            lsu_addr_i  = vecs[i].laddr;
            lsu_wdata_i = vecs[i].lwdata;
            do_txn(vecs[i].e_if, vecs[i].e_lsu, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wdata,
                   vecs[i].dly, vecs[i].sdata);
            if_req_i  = 1'b0;
            lsu_req_i = 1'b0;
        end

        // Fetch held while LSU keeps requesting: four LSU grants, then fetch.
        for (int g = 0; g < 5; g++) begin
            if_req_i    = 1'b1;
            if_addr_i   = 32'h8000_0200;
            lsu_req_i   = 1'b1;
            lsu_we_i    = 1'b1;
            lsu_addr_i  = 32'h0000_5000 + 32'(4 * g);
            lsu_wdata_i = 32'(g);
            if (g < 4)
                do_txn(1'b0, 1'b1, 1'b1, 32'h0000_5000 + 32'(4 * g), 32'(g), 1, 32'h0000_0C00 + 32'(g));
            else
                do_txn(1'b1, 1'b0, 1'b0, 32'h8000_0200, 32'h0, 1, 32'h0000_0CFF);
        end
        lsu_req_i = 1'b0;
        // Count is back at zero: a fresh contention goes to the LSU.
        if_req_i    = 1'b1;
        lsu_req_i   = 1'b1;
        lsu_addr_i  = 32'h0000_5100;
        do_txn(1'b0, 1'b1, 1'b1, 32'h0000_5100, lsu_wdata_i, 1, 32'h0000_0D00);
        if_req_i  = 1'b0;

        // Silent slave, then a late response that must be ignored.
        if_req_i  = 1'b1;
        if_addr_i = 32'h8000_0300;
        do_txn(1'b1, 1'b0, 1'b0, 32'h8000_0300, 32'h0, TIMEOUT + 1, 32'h0);
        slv_rvalid_i = 1'b1;
        slv_rdata_i  = 32'hAAAA_5555;
        tick();
        slv_rvalid_i = 1'b0;
        check1("late_if_rvalid", if_rvalid_o, 1'b0);
        check1("late_lsu_rvalid", lsu_rvalid_o, 1'b0);
        check1("late_bus_err", bus_err_o, 1'b0);
        check32("late_rdata", rdata_o, 32'd0);

        // Response on exactly the timeout cycle beats the timeout.
        lsu_req_i   = 1'b1;
        lsu_we_i    = 1'b0;
        lsu_addr_i  = 32'h0000_6000;
        lsu_wdata_i = 32'h0;
        do_txn(1'b0, 1'b1, 1'b0, 32'h0000_6000, 32'h0, TIMEOUT, 32'h0BAD_CAFE);

        // Reset while the LSU transaction is waiting.
        lsu_req_i   = 1'b1;
        lsu_we_i    = 1'b1;
        lsu_addr_i  = 32'h0000_7000;
        lsu_wdata_i = 32'h0000_0001;
        tick();
        check1("pre_rst_lsu_gnt", lsu_gnt_o, 1'b1);
        lsu_req_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midrst");
        slv_rvalid_i = 1'b1;
        slv_rdata_i  = 32'h0000_0077;
        tick();
        slv_rvalid_i = 1'b0;
        check_all_zero("postrst");
        last_rdata = 32'd0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h8000_0400;
        do_txn(1'b1, 1'b0, 1'b0, 32'h8000_0400, 32'h0, 1, 32'h0000_0013);

        // Random traffic against the transaction-level model.
        starve_m = 0;
        for (int r = 0; r < 40; r++) begin
            if (!if_req_i && ($urandom_range(0, 1) == 1)) begin
                if_req_i  = 1'b1;
                if_addr_i = $urandom() & ~32'h3;
            end else if (if_req_i && ($urandom_range(0, 7) == 0)) begin
                if_req_i = 1'b0;
            end
            if (!lsu_req_i && ($urandom_range(0, 1) == 1)) begin
                lsu_req_i   = 1'b1;
                lsu_we_i    = 1'($urandom_range(0, 1));
                lsu_addr_i  = $urandom();
                lsu_wdata_i = $urandom();
            end else if (lsu_req_i && ($urandom_range(0, 7) == 0)) begin
                lsu_req_i = 1'b0;
            end
            w_lsu = lsu_req_i && !(if_req_i && (starve_m == STARVE_LIMIT));
            w_if  = !w_lsu && if_req_i;
            if (w_lsu && if_req_i && (starve_m < STARVE_LIMIT)) starve_m = starve_m + 1;
            if (w_if) starve_m = 0;
            dly   = ($urandom_range(0, 15) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 3));
            sdata = $urandom();
            do_txn(w_if, w_lsu, w_if ? 1'b0 : lsu_we_i, w_if ? if_addr_i : lsu_addr_i,
                   w_if ? 32'h0 : lsu_wdata_i, dly, sdata);
        end
        if_req_i  = 1'b0;
        lsu_req_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
